// File: rtl/dram_seq_pkg.sv
// Shared definitions for the DRAM command sequencer.
//   state_t / St*  : sequencer FSM state encoding
//   cmd_t / Cmd*   : DRAM pin patterns, packed as {RASn, CASn, WEn[3:0]}
//   cmd_write()    : WRITE pattern with per-byte enables taken from the strobes
//   Def*           : default address field widths and timing counter width
package dram_seq_pkg;

    localparam int unsigned DefRowW = 11;
    localparam int unsigned DefColW = 10;
    localparam int unsigned DefCntW = 4;

    typedef logic [3:0] state_t;

    localparam state_t StIdle    = 4'd0;
    localparam state_t StPre     = 4'd1;
    localparam state_t StPreWait = 4'd2;
    localparam state_t StAct     = 4'd3;
    localparam state_t StActWait = 4'd4;
    localparam state_t StCol     = 4'd5;
    localparam state_t StRdWait  = 4'd6;
    localparam state_t StWrWait  = 4'd7;
    localparam state_t StRsp     = 4'd8;

    typedef logic [5:0] cmd_t;

    localparam cmd_t CmdNop = 6'b11_1111;
    localparam cmd_t CmdPre = 6'b01_0000;
    localparam cmd_t CmdAct = 6'b01_1111;
    localparam cmd_t CmdRd  = 6'b10_1111;
    localparam cmd_t CmdWr  = 6'b10_0000;

    // Byte enables are active-low on the pins, so a zero strobe gives WEn=F.
    function automatic cmd_t cmd_write(input logic [3:0] wstrb);
        return {CmdWr[5:4], ~wstrb};
    endfunction

endpackage

// File: rtl/dram_timer.sv
// Loadable down-counter used for the precharge, activate and write-recovery gaps.
//   clk, rst     : clock, asynchronous active-high reset
//   load_i       : load load_val_i this cycle (takes priority over counting)
//   load_val_i   : value to load
//   done_o       : counter has reached zero
module dram_timer
    import dram_seq_pkg::*;
#(
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/dram_cmd_sequencer.sv
// Open-page DRAM command sequencer: takes single-word requests, issues
// PRECHARGE / ACTIVATE / READ / WRITE with programmable gaps and returns a
// read word or write acknowledge.
//   clk, rst                       : dram_clk, asynchronous active-high reset
//   req_valid/ready/write/addr/... : request channel (ready only in idle)
//   rsp_valid/ready/rdata          : response channel, held until accepted
//   DRAM_*                         : registered command pins, read data return
module dram_cmd_sequencer
    import dram_seq_pkg::*;
#(
    parameter int unsigned ROW_W = DefRowW,
    parameter int unsigned COL_W = DefColW,
    parameter int unsigned T_RP  = 5,
    parameter int unsigned T_RCD = 5,
    parameter int unsigned T_WR  = 5,
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ROW_W+COL_W-1:0] req_addr,
    input  logic [31:0]            req_wdata,
    input  logic [3:0]             req_wstrb,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [31:0]            rsp_rdata,
    output logic                   DRAM_CSn,
    output logic                   DRAM_RASn,
    output logic                   DRAM_CASn,
    output logic [3:0]             DRAM_WEn,
    output logic [ROW_W-1:0]       DRAM_A,
    output logic [31:0]            DRAM_D,
    input  logic [31:0]            DRAM_Q,
    input  logic                   DRAM_valid
);

    localparam int unsigned ADDR_W = ROW_W + COL_W;

    // The timer is loaded on entry to a command state, so the command cycle
    // itself counts as the first cycle of the gap.
    localparam logic [CNT_W-1:0] RpLoad  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] RcdLoad = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] WrLoad  = CNT_W'(T_WR - 1);

    state_t             state_q, state_d;
    logic               row_open_q, row_open_d;
    logic [ROW_W-1:0]   open_row_q, open_row_d;
    logic               wr_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         wstrb_q;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    cmd_t               cmd_q, cmd_d;
    logic               csn_q, csn_d;
    logic [ROW_W-1:0]   a_q, a_d;
    logic [31:0]        d_q, d_d;

    logic               accept;
    logic               cur_write;
    logic [ADDR_W-1:0]  cur_addr;
    logic [31:0]        cur_wdata;
    logic [3:0]         cur_wstrb;
    logic [ROW_W-1:0]   cur_row;
    logic [COL_W-1:0]   cur_col;
    logic               timer_load;
    logic [CNT_W-1:0]   timer_val;
    logic               timer_done;

    assign req_ready = (state_q == StIdle);
    assign accept    = req_valid && req_ready;

    // On the accept cycle the latch is not yet loaded, so use the live request.
    assign cur_write = accept ? req_write : wr_q;
    assign cur_addr  = accept ? req_addr  : addr_q;
    assign cur_wdata = accept ? req_wdata : wdata_q;
    assign cur_wstrb = accept ? req_wstrb : wstrb_q;
    assign cur_row   = cur_addr[ADDR_W-1:COL_W];
    assign cur_col   = cur_addr[COL_W-1:0];

    dram_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .done_o     (timer_done)
    );

    always_comb begin
        state_d     = state_q;
        row_open_d  = row_open_q;
        open_row_d  = open_row_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        timer_load  = 1'b0;
        timer_val   = '0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    timer_load = 1'b1;
                    if (row_open_q && (cur_row == open_row_q)) begin
                        state_d   = StCol;
                        timer_val = WrLoad;
                    end else if (row_open_q) begin
                        state_d   = StPre;
                        timer_val = RpLoad;
                    end else begin
                        state_d   = StAct;
                        timer_val = RcdLoad;
                    end
                end
            end
            StPre, StPreWait: begin
                row_open_d = 1'b0;
                if (timer_done) begin
                    state_d    = StAct;
                    timer_load = 1'b1;
                    timer_val  = RcdLoad;
                end else begin
                    state_d = StPreWait;
                end
            end
            StAct, StActWait: begin
                row_open_d = 1'b1;
                open_row_d = cur_row;
                if (timer_done) begin
                    state_d    = StCol;
                    timer_load = 1'b1;
                    timer_val  = WrLoad;
                end else begin
                    state_d = StActWait;
                end
            end
            StCol, StWrWait: begin
                if (!cur_write) begin
                    state_d = StRdWait;
                end else if (timer_done) begin
                    state_d     = StRsp;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    state_d = StWrWait;
                end
            end
            StRdWait: begin
                if (DRAM_valid) begin
                    state_d     = StRsp;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = DRAM_Q;
                end
            end
            StRsp: begin
                if (rsp_ready) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pins are decoded from the next state so each command shows in the
    // first cycle spent in its state.
    always_comb begin
        cmd_d = CmdNop;
        csn_d = (state_d == StIdle);
        a_d   = a_q;
        d_d   = d_q;
        case (state_d)
            StPre: cmd_d = CmdPre;
            StAct: begin
                cmd_d = CmdAct;
                a_d   = cur_row;
            end
            StCol: begin
                a_d = ROW_W'(cur_col);
                if (cur_write) begin
                    cmd_d = cmd_write(cur_wstrb);
                    d_d   = cur_wdata;
                end else begin
                    cmd_d = CmdRd;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            row_open_q  <= 1'b0;
            open_row_q  <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            cmd_q       <= CmdNop;
            csn_q       <= 1'b1;
            a_q         <= '0;
            d_q         <= '0;
        end else begin
            state_q     <= state_d;
            row_open_q  <= row_open_d;
            open_row_q  <= open_row_d;
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
            end
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            cmd_q       <= cmd_d;
            csn_q       <= csn_d;
            a_q         <= a_d;
            d_q         <= d_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign DRAM_CSn  = csn_q;
    assign {DRAM_RASn, DRAM_CASn, DRAM_WEn} = cmd_q;
    assign DRAM_A    = a_q;
    assign DRAM_D    = d_q;

endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// Self-checking bench for dram_cmd_sequencer: table of transactions with
// expected command timing, a DRAM read model, and a response scoreboard.
module tb_dram_cmd_sequencer;

    localparam int ROW_W = 11;
    localparam int COL_W = 10;

    localparam logic [5:0] P_PRE = 6'b01_0000;
    localparam logic [5:0] P_ACT = 6'b01_1111;
    localparam logic [5:0] P_RD  = 6'b10_1111;

    typedef struct {
        bit          wr;
        logic [10:0] row;
        logic [9:0]  col;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] qdata;
        int          pre_c;
        int          act_c;
        int          col_c;
        int          rsp_c;
        int          hold;
        int          stray_c;
    } vec_t;

    typedef struct {
        int          rel;
        logic [5:0]  pat;
        logic [10:0] a;
        logic [31:0] d;
    } cmd_rec_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   req_valid = 1'b0;
    logic                   req_ready;
    logic                   req_write = 1'b0;
    logic [ROW_W+COL_W-1:0] req_addr = '0;
    logic [31:0]            req_wdata = '0;
    logic [3:0]             req_wstrb = '0;
    logic                   rsp_valid;
    logic                   rsp_ready = 1'b0;
    logic [31:0]            rsp_rdata;
    logic                   DRAM_CSn;
    logic                   DRAM_RASn;
    logic                   DRAM_CASn;
    logic [3:0]             DRAM_WEn;
    logic [ROW_W-1:0]       DRAM_A;
    logic [31:0]            DRAM_D;
    logic [31:0]            DRAM_Q;
    logic                   DRAM_valid;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          accept_cyc = 0;
    int          rd_cnt = 0;
    int          rd_delay = 3;
    logic        model_valid = 1'b0;
    logic        stray_valid = 1'b0;
    logic [31:0] model_q = '0;
    logic        rsp_valid_prev = 1'b0;
    logic [31:0] exp_q[$];
    cmd_rec_t    cmd_q[$];
    vec_t        vecs[7];

    dram_cmd_sequencer #(
        .ROW_W (ROW_W),
        .COL_W (COL_W),
        .T_RP  (5),
        .T_RCD (5),
        .T_WR  (5),
        .CNT_W (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .DRAM_CSn   (DRAM_CSn),
        .DRAM_RASn  (DRAM_RASn),
        .DRAM_CASn  (DRAM_CASn),
        .DRAM_WEn   (DRAM_WEn),
        .DRAM_A     (DRAM_A),
        .DRAM_D     (DRAM_D),
        .DRAM_Q     (DRAM_Q),
        .DRAM_valid (DRAM_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign DRAM_valid = model_valid | stray_valid;
    assign DRAM_Q     = stray_valid ? 32'hBAD0_BAD0 : (model_valid ? model_q : 32'h5555_AAAA);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // DRAM read model: data returned rd_delay cycles after a READ command.
    always @(negedge clk) begin
        if (!DRAM_CSn && {DRAM_RASn, DRAM_CASn, DRAM_WEn} == P_RD) begin
            rd_cnt      <= rd_delay;
            model_valid <= 1'b0;
        end else if (rd_cnt > 0) begin
            rd_cnt      <= rd_cnt - 1;
            model_valid <= (rd_cnt == 1);
        end else begin
            model_valid <= 1'b0;
        end
    end

    // Command log, NOP pattern check and response scoreboard.
    always @(negedge clk) begin
        if (!DRAM_CSn && DRAM_RASn && DRAM_CASn)
            check("nop_wen", 32'(DRAM_WEn), 32'hF);
        if (!DRAM_CSn && !(DRAM_RASn && DRAM_CASn))
            cmd_q.push_back('{cyc - accept_cyc, {DRAM_RASn, DRAM_CASn, DRAM_WEn}, DRAM_A, DRAM_D});
        if (rsp_valid && !rsp_valid_prev) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rsp_unexpected: got response %h, expected none", rsp_rdata);
            end else begin
                check("rsp_rdata", rsp_rdata, exp_q.pop_front());
            end
        end
        rsp_valid_prev <= rsp_valid;
    end

    task automatic issue(input vec_t v);
        cmd_q.delete();
        model_q = v.qdata;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = {v.row, v.col};
        req_wdata = v.wdata;
        req_wstrb = v.wstrb;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        check("accept_ready", 32'(req_ready), 32'd1);
        accept_cyc = cyc;
        exp_q.push_back(v.wr ? 32'h0 : v.qdata);
        @(negedge clk);
        // Scramble the request after accept; the DUT must use its latched copy.
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 21'($urandom);
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
    endtask

    task automatic finish_txn(input vec_t v);
        int          rel;
        bit          got;
        int          n;
        int          ecyc[3];
        logic [5:0]  epat[3];
        logic [31:0] ea[3];
        logic [31:0] ed[3];
        bit          ck_a[3];
        bit          ck_d[3];
        logic [31:0] exp_rd;
        got = 1'b0;
        rel = 0;
        for (int i = 0; i < 200; i++) begin
            rel = cyc - accept_cyc;
            stray_valid = (rel == v.stray_c);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        stray_valid = 1'b0;
        check("rsp_seen", 32'(got), 32'd1);
        check("rsp_cycle", rel, v.rsp_c);
        exp_rd = v.wr ? 32'h0 : v.qdata;
        if (got) begin
            for (int h = 0; h < v.hold; h++) begin
                check("hold_valid", 32'(rsp_valid), 32'd1);
                check("hold_rdata", rsp_rdata, exp_rd);
                check("hold_req_ready", 32'(req_ready), 32'd0);
                @(negedge clk);
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            check("rsp_clear", 32'(rsp_valid), 32'd0);
            check("idle_ready", 32'(req_ready), 32'd1);
            check("idle_csn", 32'(DRAM_CSn), 32'd1);
        end
        n = 0;
        for (int i = 0; i < 3; i++) begin
            ck_a[i] = 1'b0;
            ck_d[i] = 1'b0;
            ea[i]   = '0;
            ed[i]   = '0;
        end
        if (v.pre_c >= 0) begin
            ecyc[n] = v.pre_c;
            epat[n] = P_PRE;
            n++;
        end
        if (v.act_c >= 0) begin
            ecyc[n] = v.act_c;
            epat[n] = P_ACT;
            ea[n]   = 32'(v.row);
            ck_a[n] = 1'b1;
            n++;
        end
        ecyc[n] = v.col_c;
        epat[n] = v.wr ? {2'b10, ~v.wstrb} : P_RD;
        ea[n]   = 32'(v.col);
        ck_a[n] = 1'b1;
        ck_d[n] = v.wr;
        ed[n]   = v.wdata;
        n++;
        check("cmd_count", 32'(cmd_q.size()), n);
        for (int i = 0; i < n && i < cmd_q.size(); i++) begin
            check($sformatf("cmd%0d_cycle", i), cmd_q[i].rel, ecyc[i]);
            check($sformatf("cmd%0d_pins", i), 32'(cmd_q[i].pat), 32'(epat[i]));
            if (ck_a[i]) check($sformatf("cmd%0d_addr", i), 32'(cmd_q[i].a), ea[i]);
            if (ck_d[i]) check($sformatf("cmd%0d_data", i), cmd_q[i].d, ed[i]);
        end
    endtask

    task automatic run_txn(input vec_t v);
        issue(v);
        finish_txn(v);
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_csn"}, 32'(DRAM_CSn), 32'd1);
        check({tag, "_rasn"}, 32'(DRAM_RASn), 32'd1);
        check({tag, "_casn"}, 32'(DRAM_CASn), 32'd1);
        check({tag, "_wen"}, 32'(DRAM_WEn), 32'hF);
        check({tag, "_a"}, 32'(DRAM_A), 32'h0);
        check({tag, "_d"}, DRAM_D, 32'h0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    endtask

    initial begin
        // wr row col wdata wstrb qdata pre act col rsp hold stray
        vecs[0] = '{1'b0, 11'h012, 10'h034, 32'h0, 4'h0, 32'hDEADBEEF, -1, 1, 6, 10, 0, -1};
        vecs[1] = '{1'b1, 11'h012, 10'h035, 32'h11223344, 4'b0011, 32'h0, -1, -1, 1, 6, 0, -1};
        vecs[2] = '{1'b0, 11'h013, 10'h001, 32'h0, 4'h0, 32'hCAFEF00D, 1, 6, 11, 15, 0, -1};
        vecs[3] = '{1'b1, 11'h013, 10'h3FF, 32'hA5A5A5A5, 4'h0, 32'h0, -1, -1, 1, 6, 0, -1};
        vecs[4] = '{1'b0, 11'h7FF, 10'h000, 32'h0, 4'h0, 32'h00000001, 1, 6, 11, 15, 0, -1};
        vecs[5] = '{1'b1, 11'h000, 10'h2AA, 32'h0F0F1234, 4'hF, 32'h0, 1, 6, 11, 16, 0, -1};
        vecs[6] = '{1'b0, 11'h000, 10'h005, 32'h0, 4'h0, 32'h12345678, -1, -1, 1, 5, 10, 1};

        repeat (3) @(negedge clk);
        check_reset_pins("in_reset");
        check("in_reset_req_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check_reset_pins("post_reset");
        check("post_reset_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 7; i++) run_txn(vecs[i]);

        // Reset while waiting out tRCD after a row miss.
        issue('{1'b0, 11'h055, 10'h007, 32'h0, 4'h0, 32'h0, 1, 6, 11, 15, 0, -1});
        for (int i = 0; i < 40 && (cyc - accept_cyc) < 8; i++) @(negedge clk);
        check("pre_rst_cycle", cyc - accept_cyc, 8);
        check("pre_rst_busy", 32'(DRAM_CSn), 32'd0);
        rst = 1'b1;
        #1;
        check_reset_pins("async_rst");
        check("async_rst_req_ready", 32'(req_ready), 32'd1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        // Row state was lost, so the same row needs ACTIVATE without PRECHARGE.
        run_txn('{1'b0, 11'h055, 10'h007, 32'h0, 4'h0, 32'h0BADF00D, -1, 1, 6, 10, 0, -1});

        // Stray read-valid while idle, then another during ACT_WAIT.
        @(negedge clk);
        stray_valid = 1'b1;
        @(negedge clk);
        stray_valid = 1'b0;
        check("stray_idle_rsp", 32'(rsp_valid), 32'd0);
        check("stray_idle_ready", 32'(req_ready), 32'd1);
        run_txn('{1'b0, 11'h066, 10'h008, 32'h0, 4'h0, 32'h600DDA7A, 1, 6, 11, 15, 0, 8});

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
